// File: rtl/sfifo_stream_reader.sv
// sfifo_stream_reader: sfifo read engine, 3-entry skid buffer, valid/ready stream with burst framing; optional RD_WORD_CNT_EN adds clr_cnt/words_out transfer counter
module sfifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_rempty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
`ifdef RD_WORD_CNT_EN
  ,
  input  logic             clr_cnt,
  output logic [31:0]      words_out
`endif
);
  localparam int CW = $clog2(BURST_LEN) + 1;
  logic             rdy_q;
  logic             inflight;
  logic             xfer;
  logic [1:0]       occ;
  logic [1:0]       wr_idx;
  logic [1:0]       rd_idx;
  logic [WIDTH-1:0] mem [0:2];
  logic [CW-1:0]    beat_cnt;
  assign xfer      = m_valid & m_ready;
  assign m_valid   = occ != 2'd0;
  assign m_data    = mem[rd_idx];
  assign m_last    = m_valid & (beat_cnt == CW'(BURST_LEN - 1));
  assign fifo_rinc = rdy_q & en & ~fifo_rempty & (({1'b0, occ} + {2'b0, inflight}) < 3'd3);
  // pop tracking, capture of the word popped last cycle, and buffer bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      wr_idx   <= 2'd0;
      rd_idx   <= 2'd0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      rdy_q    <= 1'b1;
      inflight <= fifo_rinc;
      occ      <= occ + {1'b0, inflight} - {1'b0, xfer};
      if (inflight) begin
        mem[wr_idx] <= fifo_rdata;
        wr_idx      <= wr_idx == 2'd2 ? 2'd0 : wr_idx + 2'd1;
      end
      if (xfer) rd_idx <= rd_idx == 2'd2 ? 2'd0 : rd_idx + 2'd1;
    end
  end
  // burst position; holds across idle gaps, wraps on the last beat of a burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt <= '0;
    else if (xfer) beat_cnt <= beat_cnt == CW'(BURST_LEN - 1) ? '0 : beat_cnt + CW'(1);
  end
`ifdef RD_WORD_CNT_EN
  // accepted-word counter; clear takes priority over a coincident transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) words_out <= '0;
    else if (clr_cnt) words_out <= '0;
    else if (xfer) words_out <= words_out + 32'd1;
  end
`endif
endmodule

// File: doc/sfifo_stream_reader.md
Name: sfifo_stream_reader

Overview:
- Read-side engine for the team's synchronous FIFO (sfifo).
- Pops words via the FIFO's rinc/rempty/rdata interface, absorbs the 1-cycle RAM read latency in a 3-entry output buffer, and presents a valid/ready stream with burst framing (m_last every BURST_LEN beats).
- Sits between sfifo and any downstream stream consumer.
- Sustains one word per cycle with no combinational path from m_ready to fifo_rinc.

Parameters:
- WIDTH, 8: data width; must match the FIFO's WIDTH.
- BURST_LEN, 16: beats per burst; m_last asserts on every BURST_LEN-th accepted beat; legal range >= 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  pop enable; 0 blocks new pops, the buffer still drains
- fifo_rempty  input  1  FIFO empty flag, valid in the current cycle
- fifo_rdata  input  WIDTH  FIFO read data, valid the cycle after fifo_rinc
- fifo_rinc  output  1  FIFO pop request
- m_valid  output  1  output beat valid
- m_ready  input  1  downstream accept
- m_data  output  WIDTH  output beat data
- m_last  output  1  final beat of the current burst

Behaviour:
- Reset (asynchronous, rst_n=0): m_valid=0, m_data=0, m_last=0, fifo_rinc=0; buffer occupancy, in-flight flag, burst counter and read/write indices all 0.
- Start flag: rdy_q resets to 0 and is set on the first clk edge after rst_n deasserts. fifo_rinc is forced 0 while rdy_q=0.
- Pop rule: fifo_rinc = rdy_q & en & ~fifo_rempty & ((occ + inflight) < 3). It is a function of registered state, en and fifo_rempty only; never of m_ready.
- In-flight tracking: inflight <= fifo_rinc each cycle.
- Capture: when inflight=1, fifo_rdata is written into buffer entry wr_idx at that clk edge.
- Pop-to-valid latency: pop in cycle N, capture at the end of N+1, m_valid=1 in cycle N+2.
- Buffer organisation: 3-entry circular buffer; wr_idx/rd_idx wrap 2->0; occ ranges 0..3.
- Occupancy update: occ += capture - (m_valid & m_ready). Simultaneous capture and accept leaves occ unchanged.
- Output: m_valid = (occ != 0). m_data = buffer[rd_idx] and is held stable while m_valid & ~m_ready.
- Handshake: a beat transfers when m_valid & m_ready. Once m_valid is asserted, it and m_data are held until accepted.
- Burst counter: beat_cnt, width $clog2(BURST_LEN)+1.
  - Increments on each transfer.
  - Wraps to 0 on the transfer where beat_cnt == BURST_LEN-1.
- m_last = m_valid & (beat_cnt == BURST_LEN-1). With BURST_LEN=1, m_last = m_valid.
- Overflow: never occurs by construction. If a capture ever arrives with occ=3, it is a design error; the bench asserts on it.
- FIFO empty: no pop is issued; m_valid drops once the buffer drains; the burst counter holds its value (bursts span idle gaps).
- en deassert mid-stream: an in-flight word is still captured; buffered words still drain; no new pops.
- Reset mid-operation: buffered and in-flight words are discarded; the burst counter restarts at 0. The FIFO is expected to be reset on the same rst_n.

Optional Feature:
- Macro: RD_WORD_CNT_EN.
- Defined:
  - Adds input clr_cnt (1 bit) and output words_out (32 bits).
  - words_out resets to 0 and increments on each transfer, wrapping at 2^32.
  - clr_cnt=1 synchronously clears words_out to 0; when clr_cnt and a transfer coincide, the clear wins.
- Undefined: neither port exists; no counter logic is present.

Test Plan:
- Reset, then FIFO preloaded with 0x01..0x05, m_ready=1, en=1 -> first fifo_rinc on the cycle after rdy_q sets; m_valid in the 2nd cycle after the first pop; m_data 0x01..0x05 on consecutive cycles; m_valid=0 afterwards.
- Backpressure: 8 words in FIFO, m_ready=0 for 10 cycles -> exactly 3 pops issued, occ=3, m_data=first word held stable; on m_ready=1, all 8 words arrive in order with no loss or duplicate.
- BURST_LEN=4, 10 words streamed -> m_last=1 on beats 4 and 8; beat_cnt=2 at the end; beat 10 has m_last=0.
- m_ready toggling 1/0 every cycle with the FIFO refilled continuously -> no fifo_rinc while occ+inflight=3; output sequence equals input sequence.
- en dropped the cycle after a pop -> that in-flight word is still delivered; no further fifo_rinc until en=1.
- rst_n asserted with occ=2 and inflight=1 -> all outputs 0 immediately (asynchronously); after release, fifo_rinc stays 0 for one cycle; with RD_WORD_CNT_EN defined, words_out=0.
